// File: rtl/update_y_accum.sv
// Complex Y accumulator: a base beat followed by up to MAX_TERMS add/subtract delta beats.
// Optional UPDATE_Y_ACCUM_SAT_EN: clamp components on overflow instead of wrapping.
module update_y_accum #(
  parameter int W         = 24,
  parameter int MAX_TERMS = 8,
  localparam int CW       = $clog2(MAX_TERMS + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*W-1:0]  in_data,
  input  logic            in_first,
  input  logic            in_last,
  input  logic            in_sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*W-1:0]  out_data,
  output logic [CW-1:0]   out_terms,
  output logic            out_ovf,
  output logic            out_err,
  output logic            err_proto
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} stateT;

  stateT         state, stateNext;
  logic [W-1:0]  accRe, accIm, reNext, imNext;
  logic [CW-1:0] cnt, cntNext, cntInc;
  logic          ovf, ovfNext, err, errNext, errProto, protoNext;
  logic          xfer;
  logic [W:0]    sumRe, sumIm;
  logic [W-1:0]  resRe, resIm;
  logic          ovfRe, ovfIm;

  function automatic logic [W:0] addSub(input logic [W-1:0] a, input logic [W-1:0] d,
                                        input logic sub);
    logic [W:0] ax, dx;
    ax = {a[W-1], a};
    dx = {d[W-1], d};
    return sub ? (ax - dx) : (ax + dx);
  endfunction

  // The extra top bit disagrees with the sign bit exactly when the result left the W-bit range.
  function automatic logic [W-1:0] fit(input logic [W:0] s);
`ifdef UPDATE_Y_ACCUM_SAT_EN
    if (s[W] != s[W-1])
      return s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else
      return s[W-1:0];
`else
    return s[W-1:0];
`endif
  endfunction

  assign in_ready  = enable & (state != DONE);
  assign xfer      = in_valid & in_ready;
  assign out_valid = (state == DONE);
  assign out_data  = out_valid ? {accRe, accIm} : '0;
  assign out_terms = cnt;
  assign out_ovf   = ovf;
  assign out_err   = err;
  assign err_proto = errProto;

  assign sumRe  = addSub(accRe, in_data[2*W-1:W], in_sub);
  assign sumIm  = addSub(accIm, in_data[W-1:0], in_sub);
  assign ovfRe  = sumRe[W] ^ sumRe[W-1];
  assign ovfIm  = sumIm[W] ^ sumIm[W-1];
  assign resRe  = fit(sumRe);
  assign resIm  = fit(sumIm);
  assign cntInc = cnt + CW'(1);

  always_comb begin
    stateNext = state;
    reNext    = accRe;
    imNext    = accIm;
    cntNext   = cnt;
    ovfNext   = ovf;
    errNext   = err;
    protoNext = 1'b0;
    case (state)
      IDLE, ACCUM: begin
        if (xfer) begin
          if (in_first) begin
            // A base beat always (re)starts a packet; inside ACCUM it is also a violation.
            protoNext = (state == ACCUM);
            reNext    = in_data[2*W-1:W];
            imNext    = in_data[W-1:0];
            cntNext   = '0;
            ovfNext   = 1'b0;
            errNext   = 1'b0;
            stateNext = in_last ? DONE : ACCUM;
          end else if (state == IDLE) begin
            protoNext = 1'b1;
          end else begin
            reNext  = resRe;
            imNext  = resIm;
            cntNext = cntInc;
            ovfNext = ovf | ovfRe | ovfIm;
            if (in_last) begin
              stateNext = DONE;
            end else if (cntInc == CW'(MAX_TERMS)) begin
              stateNext = DONE;
              errNext   = 1'b1;
            end
          end
        end
      end
      DONE: begin
        if (enable && out_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      accRe    <= '0;
      accIm    <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      err      <= 1'b0;
      errProto <= 1'b0;
    end else if (enable) begin
      state    <= stateNext;
      accRe    <= reNext;
      accIm    <= imNext;
      cnt      <= cntNext;
      ovf      <= ovfNext;
      err      <= errNext;
      errProto <= protoNext;
    end
  end

endmodule

// File: tb/tb_update_y_accum.sv
// Scoreboard bench for update_y_accum: directed scenarios plus randomized packets checked
// against an integer-arithmetic reference model.
module tb_update_y_accum;
  localparam int W  = 24;
  localparam int MT = 4;
  localparam int CW = $clog2(MT + 1);
  localparam longint HI = (longint'(1) <<< (W - 1)) - 1;
  localparam longint LO = -(longint'(1) <<< (W - 1));
  localparam longint MOD = longint'(1) <<< W;

  logic clock, reset, enable, in_valid, in_ready, in_first, in_last, in_sub;
  logic out_valid, out_ready, out_ovf, out_err, err_proto;
  logic [2*W-1:0] in_data, out_data;
  logic [CW-1:0]  out_terms;

  update_y_accum #(.W(W), .MAX_TERMS(MT)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_first(in_first), .in_last(in_last), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_terms(out_terms), .out_ovf(out_ovf), .out_err(out_err), .err_proto(err_proto)
  );

  typedef struct {
    logic [2*W-1:0] data;
    logic [CW-1:0]  terms;
    logic           ovf;
    logic           err;
  } resT;

  resT expQ[$];
  int  nCmp = 0, nFail = 0;
  int  expProto = 0, obsProto = 0;
  bit  randMode = 0;

  // reference model state
  bit     mOpen = 0;
  longint mRe, mIm;
  int     mCnt;
  bit     mOvf;

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic longint applyOp(input longint a, input longint d, input bit sub,
                                     inout bit ov);
    longint r;
    r = sub ? a - d : a + d;
    if (r > HI || r < LO) begin
      ov = 1;
`ifdef UPDATE_Y_ACCUM_SAT_EN
      r = (r > HI) ? HI : LO;
`else
      r = (r > HI) ? r - MOD : r + MOD;
`endif
    end
    return r;
  endfunction

  task automatic pushResult(input bit e);
    resT r;
    r.data  = {mRe[W-1:0], mIm[W-1:0]};
    r.terms = CW'(mCnt);
    r.ovf   = mOvf;
    r.err   = e;
    expQ.push_back(r);
    mOpen = 0;
  endtask

  task automatic modelBeat(input bit f, input bit l, input bit s, input longint re,
                           input longint im);
    if (f) begin
      if (mOpen) expProto++;
      mRe = re; mIm = im; mCnt = 0; mOvf = 0; mOpen = 1;
      if (l) pushResult(0);
    end else if (!mOpen) begin
      expProto++;
    end else begin
      mRe = applyOp(mRe, re, s, mOvf);
      mIm = applyOp(mIm, im, s, mOvf);
      mCnt++;
      if (l) pushResult(0);
      else if (mCnt == MT) pushResult(1);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic sendBeat(input bit f, input bit l, input bit s, input longint re,
                          input longint im);
    logic [W-1:0] rb, ib;
    bit got;
    rb = re[W-1:0];
    ib = im[W-1:0];
    in_data = {rb, ib}; in_first = f; in_last = l; in_sub = s; in_valid = 1;
    got = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      if (in_ready) begin got = 1; break; end
    end
    if (!got) begin
      nCmp++; nFail++;
      $display("FAIL acceptTimeout: in_ready never rose, expected acceptance");
      in_valid = 0;
      return;
    end
    @(posedge clock); #1;
    in_valid = 0;
    modelBeat(f, l, s, longint'($signed(rb)), longint'($signed(ib)));
  endtask

  function automatic longint randVal();
    logic [W-1:0] v;
    v = W'($urandom);
    if ($urandom_range(0, 2) == 0) return longint'($urandom_range(0, 200)) - 100;
    return longint'($signed(v));
  endfunction

  always @(posedge clock) begin
    #1;
    if (randMode) out_ready = ($urandom_range(0, 3) != 0);
  end

  // monitor: result pops, hold-stability while stalled, idle data, protocol pulses
  bit stall = 0;
  logic [2*W-1:0] pData;
  logic [CW-1:0]  pTerms;
  logic           pOvf, pErr;
  always @(negedge clock) begin
    if (reset) begin
      stall = 0;
    end else begin
      if (err_proto) obsProto++;
      if (out_valid) begin
        if (stall) begin
          check("holdData", 64'(out_data), 64'(pData));
          check("holdTerms", 64'(out_terms), 64'(pTerms));
          check("holdFlags", {62'd0, out_ovf, out_err}, {62'd0, pOvf, pErr});
        end
        if (out_ready && enable) begin
          stall = 0;
          if (expQ.size() == 0) begin
            nCmp++; nFail++;
            $display("FAIL unexpectedResult: got %h expected none", out_data);
          end else begin
            resT e;
            e = expQ.pop_front();
            check("resData", 64'(out_data), 64'(e.data));
            check("resTerms", 64'(out_terms), 64'(e.terms));
            check("resOvf", 64'(out_ovf), 64'(e.ovf));
            check("resErr", 64'(out_err), 64'(e.err));
          end
        end else begin
          stall = 1;
          pData = out_data; pTerms = out_terms; pOvf = out_ovf; pErr = out_err;
        end
      end else begin
        stall = 0;
        check("idleData", 64'(out_data), 64'd0);
      end
    end
  end

  initial begin
    logic [2*W-1:0] e33;
    logic [W-1:0]   e34;
    clock = 0; reset = 1; enable = 1; in_valid = 0; in_data = '0;
    in_first = 0; in_last = 0; in_sub = 0; out_ready = 0;

    repeat (2) @(negedge clock);
    check("rstValid", 64'(out_valid), 64'd0);
    check("rstData", 64'(out_data), 64'd0);
    check("rstTerms", 64'(out_terms), 64'd0);
    check("rstFlags", {61'd0, out_ovf, out_err, err_proto}, 64'd0);
    check("rstReady", 64'(in_ready), 64'd1);
    @(posedge clock); #1 reset = 0;

    // 100-5j + (10+3j) - (30+1j), stalled 5 cycles in DONE
    sendBeat(1, 0, 0, 100, -5);
    sendBeat(0, 0, 0, 10, 3);
    sendBeat(0, 1, 1, 30, 1);
    e33 = {24'd80, 24'hFFFFFD};
    @(negedge clock);
    check("latValid", 64'(out_valid), 64'd1);
    check("basicData", 64'(out_data), 64'(e33));
    check("basicTerms", 64'(out_terms), 64'd2);
    check("basicOvf", 64'(out_ovf), 64'd0);
    repeat (5) begin
      @(negedge clock);
      check("stallValid", 64'(out_valid), 64'd1);
      check("stallReady", 64'(in_ready), 64'd0);
    end
    @(posedge clock); #1 out_ready = 1;
    @(posedge clock); @(negedge clock);
    check("drainValid", 64'(out_valid), 64'd0);
    check("drainReady", 64'(in_ready), 64'd1);

    // overflow at the positive bound
    @(posedge clock); #1 out_ready = 0;
    sendBeat(1, 0, 0, 64'h7FFFF0, 0);
    sendBeat(0, 1, 0, 64'h20, 0);
`ifdef UPDATE_Y_ACCUM_SAT_EN
    e34 = 24'h7FFFFF;
`else
    e34 = 24'h800010;
`endif
    @(negedge clock);
    check("ovfReal", 64'(out_data[2*W-1:W]), 64'(e34));
    check("ovfFlag", 64'(out_ovf), 64'd1);
    @(posedge clock); #1 out_ready = 1;

    // truncation at MAX_TERMS, fifth delta lands in IDLE
    sendBeat(1, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) sendBeat(0, 0, i[0], 3, 2);
    @(negedge clock);
    check("strayProto", 64'(err_proto), 64'd1);
    @(posedge clock); #1;

    // reset mid-packet discards it
    sendBeat(1, 0, 0, 50, 60);
    sendBeat(0, 0, 0, 1, 1);
    sendBeat(0, 0, 1, 2, 2);
    reset = 1; mOpen = 0;
    #1;
    check("rstMidValid", 64'(out_valid), 64'd0);
    check("rstMidTerms", 64'(out_terms), 64'd0);
    @(posedge clock); #1 reset = 0;
    sendBeat(1, 1, 0, 7, 7);

    // enable low with a beat pending
    sendBeat(1, 0, 0, 1000, -1000);
    sendBeat(0, 0, 1, 250, 125);
    enable = 0;
    in_data = {24'd40, 24'd41}; in_first = 0; in_last = 1; in_sub = 0; in_valid = 1;
    repeat (3) begin
      @(negedge clock);
      check("disReady", 64'(in_ready), 64'd0);
    end
    @(posedge clock); #1 enable = 1;
    sendBeat(0, 1, 0, 40, 41);

    // randomized packets
    randMode = 1;
    for (int p = 0; p < 60; p++) begin
      int n;
      n = $urandom_range(0, 5);
      if ($urandom_range(0, 7) == 0) sendBeat(0, $urandom_range(0, 1), 0, randVal(), randVal());
      sendBeat(1, n == 0, $urandom_range(0, 1), randVal(), randVal());
      for (int d = 1; d <= n; d++) begin
        if ($urandom_range(0, 19) == 0)
          sendBeat(1, d == n, 0, randVal(), randVal());
        else
          sendBeat(0, d == n, $urandom_range(0, 1), randVal(), randVal());
      end
    end
    randMode = 0;
    out_ready = 1;
    for (int i = 0; i < 100 && expQ.size() != 0; i++) @(negedge clock);
    check("queueDrained", 64'(expQ.size()), 64'd0);
    repeat (3) @(negedge clock);
    check("protoCount", 64'(obsProto), 64'(expProto));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule

// File: doc/update_y_accum.md
UPDATE_Y_ACCUM -- requirements
Module: update_y_accum

Interface
REQ-001 SHALL have parameter W, default 24: signed width of each complex component (real, imag).
REQ-002 SHALL have parameter MAX_TERMS, default 8: maximum delta beats per packet; CW = clog2(MAX_TERMS+1).
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  0 freezes all state and forces in_ready=0; outputs hold.
REQ-006 SHALL have port in_valid  input  1  input beat valid.
REQ-007 SHALL have port in_ready  output  1  block accepts beat; transfer = in_valid & in_ready.
REQ-008 SHALL have port in_data  input  2W  packed {real[2W-1:W], imag[W-1:0]}, two's complement.
REQ-009 SHALL have port in_first  input  1  beat is base Y value; starts a packet.
REQ-010 SHALL have port in_last  input  1  final beat of packet.
REQ-011 SHALL have port in_sub  input  1  delta beat: 1 = subtract, 0 = add; ignored on first beat.
REQ-012 SHALL have port out_valid  output  1  result valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts result.
REQ-014 SHALL have port out_data  output  2W  accumulated Y, same packing as in_data.
REQ-015 SHALL have port out_terms  output  CW  number of delta beats applied.
REQ-016 SHALL have port out_ovf  output  1  any component overflow occurred within packet.
REQ-017 SHALL have port out_err  output  1  packet truncated at MAX_TERMS.
REQ-018 SHALL have port err_proto  output  1  one-cycle pulse on protocol violation.

Function
REQ-019 SHALL implement FSM IDLE, ACCUM, DONE; in_ready = enable & (state != DONE).
REQ-020 In IDLE, accepted beat with in_first=1 SHALL load acc=in_data, cnt=0, ovf=0, err=0; next state ACCUM, or DONE if in_last=1.
REQ-021 In IDLE, accepted beat with in_first=0 SHALL be dropped and pulse err_proto.
REQ-022 In ACCUM, accepted beat with in_first=0 SHALL update each component acc = acc +/- in_data component (per in_sub), cnt=cnt+1.
REQ-023 In ACCUM, accepted beat with in_first=1 SHALL pulse err_proto and restart the packet as REQ-020.
REQ-024 Delta beat with in_last=1 SHALL move to DONE; out_valid SHALL assert the cycle after that beat is accepted (latency 1).
REQ-025 If cnt reaches MAX_TERMS on a non-last beat, SHALL move to DONE with out_err=1; subsequent beats fall under REQ-021.
REQ-026 Component arithmetic SHALL be W+1 bits; overflow = result outside [-2^(W-1), 2^(W-1)-1]; sets sticky ovf.
REQ-027 In DONE, out_valid=1 and out_data/out_terms/out_ovf/out_err SHALL be stable until out_valid & out_ready, then IDLE next cycle.
REQ-028 out_valid SHALL be 0 outside DONE; out_data SHALL be 0 when out_valid=0.
REQ-029 enable=0 in any state SHALL hold state, acc, cnt and outputs; no transfer occurs.

Reset
REQ-030 reset=1 SHALL immediately force IDLE, acc=0, cnt=0, out_valid=0, out_data=0, out_terms=0, out_ovf=0, out_out_err=0, err_proto=0.
REQ-031 Reset mid-packet or in DONE SHALL discard the packet; no result emitted.

Configuration
REQ-032 Macro UPDATE_Y_ACCUM_SAT_EN defined: on overflow each component SHALL clamp to nearest bound; undefined: result SHALL wrap modulo 2^W. out_ovf behaviour identical in both.

Verification (W=24, MAX_TERMS=4)
REQ-033 Base 100-5j, add 10+3j, sub 30+1j (last) -> out_data 80-3j, out_terms=2, out_ovf=0, out_valid one cycle after last accept.
REQ-034 Base 0x7FFFF0 real, add 0x20 (last) -> SAT_EN: real 0x7FFFFF, out_ovf=1; without: real 0x800010, out_ovf=1.
REQ-035 out_ready=0 for 5 cycles in DONE -> out_valid and out_data stable, in_ready=0; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-036 Base then 5 non-last deltas -> DONE after 4th, out_terms=4, out_err=1; 5th beat dropped after return to IDLE with err_proto pulse.
REQ-037 reset asserted after 2 deltas -> out_valid=0 immediately, no result; next packet base 7+7j last -> out_data 7+7j, out_terms=0.
REQ-038 enable=0 for 3 cycles mid-packet with in_valid=1 -> no beats accepted, acc unchanged; result identical to uninterrupted run.
